// File: rtl/vram_writer_if.sv
// Host command and VRAM write-port signals for vram_writer.
// The master side is the host/arbiter environment; the slave side is the writer.
interface vram_writer_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              hostValid;
  logic              hostReady;
  logic              hostCmd;
  logic [ADDR_W-1:0] hostData;
  logic              vramGrant;
  logic              vramWe;
  logic [ADDR_W-1:0] vramWrAddr;
  logic [DATA_W-1:0] vramWrData;
  logic              busy;

  modport master (
    output hostValid, hostCmd, hostData, vramGrant,
    input  hostReady, vramWe, vramWrAddr, vramWrData, busy
  );

  modport slave (
    input  hostValid, hostCmd, hostData, vramGrant,
    output hostReady, vramWe, vramWrAddr, vramWrData, busy
  );
endinterface

// File: rtl/vram_writer.sv
// Host-side VRAM write path: cursor, small write FIFO and a grant-gated drain FSM.
// Optional macro VRAM_WRITER_LEVEL_EN adds the fifoLevel output (current FIFO count).
module vram_writer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_AW    = 2,
  parameter int VRAM_WORDS = 8192
) (
  input  logic          clk,
  input  logic          rst,
  vram_writer_if.slave  bus
`ifdef VRAM_WRITER_LEVEL_EN
  , output logic [FIFO_AW:0] fifoLevel
`endif
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_WORDS - 1);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]  cursor;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic push;
  logic pop;
  logic we_next;

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_empty    = (count == '0);
  assign bus.hostReady = ~fifo_full;
  assign accept        = bus.hostValid & ~fifo_full;
  assign push          = accept & bus.hostCmd;
  assign bus.busy      = ~fifo_empty | bus.vramWe;

`ifdef VRAM_WRITER_LEVEL_EN
  assign fifoLevel = count;
`endif

  // The cursor address is captured into the FIFO entry, so later set-cursor
  // commands never disturb writes that are already queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor <= '0;
    end else if (accept) begin
      if (!bus.hostCmd) begin
        cursor <= bus.hostData;
      end else if (cursor >= LAST_ADDR) begin
        cursor <= '0;
      end else begin
        cursor <= cursor + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cursor;
      data_mem[wr_ptr] <= bus.hostData[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A grant means the port is free next cycle, so popping on a granted edge
  // lands the registered strobe exactly in the free slot.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    we_next    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && bus.vramGrant) begin
          pop        = 1'b1;
          we_next    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!fifo_empty && bus.vramGrant) begin
          pop        = 1'b1;
          we_next    = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.vramWe     <= 1'b0;
      bus.vramWrAddr <= '0;
      bus.vramWrData <= '0;
    end else begin
      state      <= state_next;
      bus.vramWe <= we_next;
      if (pop) begin
        bus.vramWrAddr <= addr_mem[rd_ptr];
        bus.vramWrData <= data_mem[rd_ptr];
      end
    end
  end

endmodule
